mem_responder: RTL and testbench

Word-addressed memory responder for the multicycle ARM core. It serves the single unified instruction/data memory port that the main control FSM drives during its FETCH, MEMRD and MEMWR states. Each request from the core is accepted, held for a programmable number of wait states, then answered with a one-cycle `ready` pulse carrying read data or a write commit. The core's FSM stalls in its memory state until `ready`.

---
 rtl/mem_responder_pkg.sv | 17 +
 rtl/mem_responder_if.sv | 18 +
 rtl/mem_responder_array.sv | 41 ++++
 rtl/mem_responder.sv | 132 +++++++++++++
 tb/tb_mem_responder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the memory responder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_responder_pkg;

  localparam int MR_DEPTH_DEFAULT       = 1024;
  localparam int MR_WAIT_CYCLES_DEFAULT = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Unified instruction/data memory port between the core FSM and the responder.
// Latency: n/a (wiring only).
// Backpressure: the core holds req and its qualifiers until ready pulses.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic  req;
  logic  we;
  word_t addr;
  word_t wdata;
  word_t rdata;
  logic  ready;
  logic  busy;
  logic  fault;

  modport master (output req, we, addr, wdata, input rdata, ready, busy, fault);
  modport slave  (input req, we, addr, wdata, output rdata, ready, busy, fault);
endinterface

// File: rtl/mem_responder_array.sv
// Single-port synchronous word RAM with registered read; contents are never reset.
// Latency: one edge for both read data and write commit.
// Backpressure: none; every enabled cycle performs exactly one access.
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = MR_DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_we,
  input  logic          i_clr,
  input  logic [AW-1:0] i_idx,
  input  word_t         i_wdata,
  output word_t         o_rdata
);

  word_t r_mem [DEPTH];
  word_t r_rdata;

  // Write port: storage deliberately has no reset so contents survive a core reset.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  // Read register: i_clr returns zero instead of the stored word (rejected access).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_en && !i_we) begin
      r_rdata <= i_clr ? '0 : r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder: accepts a core request, waits WAIT_CYCLES, pulses ready.
// Latency: WAIT_CYCLES+1 cycles from acceptance to ready; one access per WAIT_CYCLES+2 cycles.
// Backpressure: busy while in flight; inputs ignored until IDLE. MEM_RESPONDER_ALIGN_CHECK_EN enables misalignment faults.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH       = MR_DEPTH_DEFAULT,
  parameter int WAIT_CYCLES = MR_WAIT_CYCLES_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  word_t         r_addr;
  word_t         r_wdata;
  logic          r_ready;
  logic          r_busy;
  logic          r_fault;

  logic          w_accept;
  logic          w_go_resp;
  logic          w_acc_we;
  word_t         w_acc_addr;
  word_t         w_acc_wdata;
  logic          w_acc_fault;
  logic          w_ram_en;
  word_t         w_rdata;
  logic          w_unused;

  // Access qualifiers: live bus in IDLE (zero-wait path commits on the accept edge), latched copy otherwise.
  always_comb begin
    w_accept    = (r_state == IDLE) && bus.req && !reset;
    w_go_resp   = !reset && (((WAIT_CYCLES == 0) && w_accept) ||
                             ((r_state == WAIT) && (r_cnt == CW'(1))));
    w_acc_we    = (r_state == IDLE) ? bus.we    : r_we;
    w_acc_addr  = (r_state == IDLE) ? bus.addr  : r_addr;
    w_acc_wdata = (r_state == IDLE) ? bus.wdata : r_wdata;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    w_acc_fault = (w_acc_addr[1:0] != 2'b00);
`else
    w_acc_fault = 1'b0;
`endif
    // A misaligned write is dropped; a misaligned read still clocks the read register to zero.
    w_ram_en    = w_go_resp && !(w_acc_fault && w_acc_we);
  end

  // Address bits outside the word index alias and are intentionally discarded.
  assign w_unused = ^{w_acc_addr[31:AW+2], w_acc_addr[1:0]};

  // Control FSM with registered ready/busy/fault.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          r_fault <= 1'b0;
          r_busy  <= 1'b0;
          if (bus.req) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_cnt   <= CW'(WAIT_CYCLES);
            r_busy  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              r_state <= RESP;
              r_ready <= 1'b1;
              r_fault <= w_acc_fault;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= RESP;
            r_ready <= 1'b1;
            r_fault <= w_acc_fault;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_fault <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_fault <= 1'b0;
        end
      endcase
    end
  end

  mem_responder_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_ram_en),
    .i_we    (w_acc_we),
    .i_clr   (w_acc_fault),
    .i_idx   (w_acc_addr[AW+1:2]),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_rdata)
  );

  assign bus.rdata = w_rdata;
  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.fault = r_fault;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances side by side.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if bus ();
  mem_responder_if bus0 ();

  mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  localparam logic  EXP_ALIGN_FAULT = 1'b1;
  localparam word_t EXP_WORD8       = 32'h0000_0005;
  localparam word_t EXP_RD22        = 32'h0000_0000;
`else
  localparam logic  EXP_ALIGN_FAULT = 1'b0;
  localparam word_t EXP_WORD8       = 32'h0000_0007;
  localparam word_t EXP_RD22        = 32'h0000_0007;
`endif

  // One access on the WAIT_CYCLES=2 instance; lat=0 means ready never came.
  task automatic access(input logic we, input word_t addr, input word_t wdata,
                        output int lat, output word_t rd, output logic flt,
                        output logic busy_ok, output logic post_rdy, output logic post_busy);
    lat = 0; rd = '0; flt = 1'b0; busy_ok = 1'b1;
    @(negedge clk);
    bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wdata;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.ready === 1'b1) begin
        lat = k; rd = bus.rdata; flt = bus.fault;
        break;
      end
    end
    bus.req = 1'b0;
    @(negedge clk);
    post_rdy  = bus.ready;
    post_busy = bus.busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
    n_tests++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    n_tests++; if (bus0.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b want 0", bus0.ready); end
    n_tests++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy0: got %b want 0", bus0.busy); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat; word_t rd; logic flt, bok, prdy, pbsy;
    access(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, flt, bok, prdy, pbsy);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d want 3", lat); end
    n_tests++; if (bok !== 1'b1) begin n_fail++; $display("FAIL wr_busy_inflight: got %b want 1", bok); end
    n_tests++; if (prdy !== 1'b0) begin n_fail++; $display("FAIL wr_ready_single: got %b want 0", prdy); end
    n_tests++; if (pbsy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_fall: got %b want 0", pbsy); end
    n_tests++; if (flt !== 1'b0) begin n_fail++; $display("FAIL wr_fault: got %b want 0", flt); end
    access(1'b0, 32'h10, 32'h0, lat, rd, flt, bok, prdy, pbsy);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d want 3", lat); end
    n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    n_tests++; if (bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data_held: got %h want deadbeef", bus.rdata); end
  endtask

  task automatic test_wrap();
    int lat; word_t rd; logic flt, bok, prdy, pbsy;
    access(1'b1, 32'h1000, 32'hA5A5A5A5, lat, rd, flt, bok, prdy, pbsy);
    access(1'b0, 32'h0, 32'h0, lat, rd, flt, bok, prdy, pbsy);
    n_tests++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL wrap_data: got %h want a5a5a5a5", rd); end
    access(1'b0, 32'h10, 32'h0, lat, rd, flt, bok, prdy, pbsy);
    n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wrap_neighbour: got %h want deadbeef", rd); end
  endtask

  task automatic test_latch();
    int lat; word_t rd; logic flt, bok, prdy, pbsy;
    logic seen;
    access(1'b1, 32'h44, 32'h33333333, lat, rd, flt, bok, prdy, pbsy);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h40; bus.wdata = 32'h11111111;
    @(negedge clk);
    bus.we = 1'b0; bus.addr = 32'h44; bus.wdata = 32'h22222222;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.ready === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    bus.req = 1'b0;
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL latch_ready: got %b want 1", seen); end
    @(negedge clk);
    access(1'b0, 32'h40, 32'h0, lat, rd, flt, bok, prdy, pbsy);
    n_tests++; if (rd !== 32'h11111111) begin n_fail++; $display("FAIL latch_orig_data: got %h want 11111111", rd); end
    access(1'b0, 32'h44, 32'h0, lat, rd, flt, bok, prdy, pbsy);
    n_tests++; if (rd !== 32'h33333333) begin n_fail++; $display("FAIL latch_other_word: got %h want 33333333", rd); end
  endtask

  task automatic test_reset_midwait();
    int lat; word_t rd; logic flt, bok, prdy, pbsy;
    access(1'b1, 32'h20, 32'h5, lat, rd, flt, bok, prdy, pbsy);
    access(1'b0, 32'h20, 32'h0, lat, rd, flt, bok, prdy, pbsy);
    n_tests++; if (rd !== 32'h5) begin n_fail++; $display("FAIL rst_pre_read: got %h want 5", rd); end
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h20; bus.wdata = 32'h99;
    @(negedge clk);
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_wait: got %b want 1", bus.busy); end
    reset = 1'b1;
    #1;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_async: got %b want 0", bus.busy); end
    n_tests++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_async: got %b want 0", bus.ready); end
    n_tests++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata_async: got %h want 0", bus.rdata); end
    @(negedge clk);
    bus.req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    access(1'b0, 32'h20, 32'h0, lat, rd, flt, bok, prdy, pbsy);
    n_tests++; if (rd !== 32'h5) begin n_fail++; $display("FAIL rst_write_discarded: got %h want 5", rd); end
  endtask

  task automatic test_align();
    int lat; word_t rd; logic flt, bok, prdy, pbsy;
    access(1'b1, 32'h22, 32'h7, lat, rd, flt, bok, prdy, pbsy);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL align_latency: got %0d want 3", lat); end
    n_tests++; if (flt !== EXP_ALIGN_FAULT) begin n_fail++; $display("FAIL align_wr_fault: got %b want %b", flt, EXP_ALIGN_FAULT); end
    access(1'b0, 32'h20, 32'h0, lat, rd, flt, bok, prdy, pbsy);
    n_tests++; if (rd !== EXP_WORD8) begin n_fail++; $display("FAIL align_word8: got %h want %h", rd, EXP_WORD8); end
    n_tests++; if (flt !== 1'b0) begin n_fail++; $display("FAIL align_aligned_fault: got %b want 0", flt); end
    access(1'b0, 32'h22, 32'h0, lat, rd, flt, bok, prdy, pbsy);
    n_tests++; if (rd !== EXP_RD22) begin n_fail++; $display("FAIL align_rd_data: got %h want %h", rd, EXP_RD22); end
    n_tests++; if (flt !== EXP_ALIGN_FAULT) begin n_fail++; $display("FAIL align_rd_fault: got %b want %b", flt, EXP_ALIGN_FAULT); end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h10; bus.wdata = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_rdy = ((k % 4) == 3);
      n_tests++;
      if (bus.ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want %b", k, bus.ready, exp_rdy); end
      if (exp_rdy) begin
        n_tests++;
        if (bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h want deadbeef", k, bus.rdata); end
      end
    end
    bus.req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_zero_wait();
    logic exp_rdy;
    @(negedge clk);
    bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 32'h0; bus0.wdata = 32'h1;
    @(negedge clk);
    n_tests++; if (bus0.ready !== 1'b1) begin n_fail++; $display("FAIL w0_wr_ready: got %b want 1", bus0.ready); end
    bus0.we = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_rdy = ((k % 2) == 0);
      n_tests++;
      if (bus0.ready !== exp_rdy) begin n_fail++; $display("FAIL w0_ready[%0d]: got %b want %b", k, bus0.ready, exp_rdy); end
      n_tests++;
      if (bus0.busy !== exp_rdy) begin n_fail++; $display("FAIL w0_busy[%0d]: got %b want %b", k, bus0.busy, exp_rdy); end
      if (exp_rdy) begin
        n_tests++;
        if (bus0.rdata !== 32'h1) begin n_fail++; $display("FAIL w0_rdata[%0d]: got %h want 1", k, bus0.rdata); end
      end
    end
    bus0.req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_latch();
    test_reset_midwait();
    test_align();
    test_back_to_back();
    test_zero_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
